// File: rtl/nibble_serializer.sv
// nibble_serializer: serializes a 4*NIBBLES-bit word into 4-bit nibbles, LSB- or MSB-first per word.
// Define NIBBLE_SER_PREFETCH_EN to add a one-word prefetch register for zero-bubble back-to-back words.
module nibble_serializer #(
    parameter int NIBBLES = 8,
    localparam int IDX_W = $clog2(NIBBLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_word,
    input  logic                 in_reverse,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_nibble,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic                 busy
);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NIBBLES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [4*NIBBLES-1:0] word_q;
    logic                 rev_q;
    logic                 xfer;
    logic                 accept;
    logic                 last_hit;

    function automatic logic [IDX_W-1:0] first_idx(input logic rev);
        return rev ? IDX_MAX : IDX_W'(0);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i, input logic rev);
        return rev ? i - 1'b1 : i + 1'b1;
    endfunction

    // All outputs are decoded from state registers only; no in_* to out_* path.
    assign busy       = (state == SEND);
    assign out_valid  = busy;
    assign out_idx    = idx;
    assign out_nibble = word_q[{idx, 2'b00} +: 4];
    assign last_hit   = (idx == (rev_q ? IDX_W'(0) : IDX_MAX));
    assign out_last   = busy && last_hit;
    assign xfer       = out_valid && out_ready;
    assign accept     = in_valid && in_ready;

`ifdef NIBBLE_SER_PREFETCH_EN
    logic [4*NIBBLES-1:0] pf_word;
    logic                 pf_rev;
    logic                 pf_full;

    assign in_ready = !pf_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            word_q  <= '0;
            rev_q   <= 1'b0;
            pf_word <= '0;
            pf_rev  <= 1'b0;
            pf_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q <= in_word;
                        rev_q  <= in_reverse;
                        idx    <= first_idx(in_reverse);
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (xfer && last_hit) begin
                        // in_ready is low while the prefetch is full, so accept and pf_full never coincide.
                        if (pf_full) begin
                            word_q  <= pf_word;
                            rev_q   <= pf_rev;
                            idx     <= first_idx(pf_rev);
                            pf_full <= 1'b0;
                        end else if (accept) begin
                            word_q <= in_word;
                            rev_q  <= in_reverse;
                            idx    <= first_idx(in_reverse);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            idx <= next_idx(idx, rev_q);
                        end
                        if (accept) begin
                            pf_word <= in_word;
                            pf_rev  <= in_reverse;
                            pf_full <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
`else
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            word_q <= '0;
            rev_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q <= in_word;
                        rev_q  <= in_reverse;
                        idx    <= first_idx(in_reverse);
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last_hit) begin
                            state <= IDLE;
                        end else begin
                            idx <= next_idx(idx, rev_q);
                        end
                    end
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed self-checking bench for nibble_serializer (default NIBBLES=8).
module tb_nibble_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_reverse;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_nibble;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    nibble_serializer #(.NIBBLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_reverse(in_reverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_nibble(out_nibble),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] nib, input logic [2:0] idx,
                           input logic last);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " out_nibble"}, 32'(out_nibble), 32'(nib));
        chk({tag, " out_idx"}, 32'(out_idx), 32'(idx));
        chk({tag, " out_last"}, 32'(out_last), 32'(last));
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_last"}, 32'(out_last), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [3:0] msb_exp [8] = '{4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] bp_exp  [8] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [3:0] rs_exp  [8] = '{4'h3, 4'h2, 4'h1, 4'h0, 4'hD, 4'hC, 4'hB, 4'hA};

    initial begin
        int k;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_word    = '0;
        in_reverse = 1'b0;
        out_ready  = 1'b0;
        step();
        step();
        chk_idle("reset");
        chk("reset out_nibble", 32'(out_nibble), 32'd0);
        chk("reset out_idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        step();

        // LSB-first, full throughput
        in_word = 32'h8765_4321; in_reverse = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out("lsb", 4'(i + 1), 3'(i), i == 7);
            step();
        end
        chk_idle("lsb done");

        // MSB-first
        in_word = 32'h0600_0000; in_reverse = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out("msb", msb_exp[i], 3'(7 - i), i == 7);
            step();
        end
        chk_idle("msb done");

        // Backpressure, out_ready alternating starting at 0
        in_word = 32'hFFFF_0FFF; in_reverse = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = c[0];
            chk_out("bp", bp_exp[k], 3'(k), k == 7);
            step();
            if (out_ready) k++;
        end
        chk("bp transfers", 32'(k), 32'd8);
        out_ready = 1'b1;
        chk_idle("bp done");

        // Back-to-back words with in_valid held
        in_word = 32'h1111_1111; in_reverse = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_word = 32'h2222_2222;
`ifdef NIBBLE_SER_PREFETCH_EN
        for (int i = 0; i < 16; i++) begin
            chk_out("b2b", (i < 8) ? 4'h1 : 4'h2, 3'(i % 8), (i % 8) == 7);
            step();
            if (i == 0) in_valid = 1'b0;
        end
`else
        for (int i = 0; i < 8; i++) begin
            chk_out("b2b w1", 4'h1, 3'(i), i == 7);
            step();
        end
        chk("b2b gap out_valid", 32'(out_valid), 32'd0);
        chk("b2b gap in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out("b2b w2", 4'h2, 3'(i), i == 7);
            step();
        end
`endif
        chk_idle("b2b done");

        // Reset after three transfers, then a fresh word
        in_word = 32'h8765_4321; in_reverse = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_out("pre-rst", 4'(i + 1), 3'(i), 1'b0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("mid rst");
        in_word = 32'hABCD_0123; in_reverse = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out("post-rst", rs_exp[i], 3'(i), i == 7);
            step();
        end
        chk_idle("post-rst done");

        // in_reverse and in_word toggled during SEND must not affect the word in flight
        in_word = 32'h8765_4321; in_reverse = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_word  = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            in_reverse = ~in_reverse;
            chk_out("dirlatch", 4'(i + 1), 3'(i), i == 7);
            step();
        end
        chk_idle("dirlatch done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
